// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: NxN output-stationary systolic matrix multiplier, C = A x B.
// A is NxK, B is KxN, and K (k_len) is chosen per job, up to K_MAX.
// Operand beats arrive column-of-A / row-of-B wide. The engine skews them internally
// and returns C one row at a time, with backpressure on the result side.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start, k_len       job request (taken in IDLE only) and the job's inner dimension
//   busy               high in every state except IDLE
//   in_valid, in_ready operand beat handshake (in_ready is high only in LOAD)
//   a_vec, b_vec       lane i = A[i][k], lane j = B[k][j]
//   c_valid, c_ready   result row handshake
//   c_row, c_row_idx   lane j = C[r][j]; r is the row index
//   done               pulse on the cycle the last row is accepted
module systolic_mm_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 4,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(K_MAX),
    parameter int unsigned SIGNED     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*DATA_WIDTH-1:0]       a_vec,
    input  logic [N*DATA_WIDTH-1:0]       b_vec,
    output logic                          c_valid,
    input  logic                          c_ready,
    output logic [N*ACC_WIDTH-1:0]        c_row,
    output logic [$clog2(N)-1:0]          c_row_idx,
    output logic                          done
);

    localparam int unsigned KW  = $clog2(K_MAX + 1);
    localparam int unsigned RW  = $clog2(N);
    localparam int unsigned PW  = 2 * DATA_WIDTH;
    localparam int unsigned DCW = $clog2(2 * N);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    state_t          state;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   beat_q;
    logic [DCW-1:0]  drain_q;

    logic            clr;
    logic            adv;
    logic            load_beat;

    logic [DATA_WIDTH-1:0] a_lane [N];
    logic [DATA_WIDTH-1:0] b_lane [N];
    logic [DATA_WIDTH-1:0] a_edge [N];
    logic [DATA_WIDTH-1:0] b_edge [N];
    logic [DATA_WIDTH-1:0] a_sk   [1:N-1][N-1];
    logic [DATA_WIDTH-1:0] b_sk   [1:N-1][N-1];
    logic [DATA_WIDTH-1:0] a_h    [N][N-1];
    logic [DATA_WIDTH-1:0] b_v    [N-1][N];
    logic [DATA_WIDTH-1:0] a_in   [N][N];
    logic [DATA_WIDTH-1:0] b_in   [N][N];
    logic [ACC_WIDTH-1:0]  prod   [N][N];
    logic [ACC_WIDTH-1:0]  acc    [N][N];

    logic [RW-1:0]          row_sel;
    logic [N*ACC_WIDTH-1:0] row_nxt;

    // Product extended to accumulator width, zero- or sign-extended
    function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic signed [PW-1:0] ps;
        logic [PW-1:0]        pu;
        ps = PW'($signed(a)) * PW'($signed(b));
        pu = PW'(a) * PW'(b);
        if (SIGNED != 0) return ACC_WIDTH'(ps);
        else             return ACC_WIDTH'(pu);
    endfunction

    assign clr       = (state == IDLE) && start;
    assign adv       = (state == LOAD) || (state == DRAIN);
    assign load_beat = (state == LOAD) && in_valid;
    assign done      = (state == OUT) && c_ready && (c_row_idx == ROW_LAST);

    // Lane gating, skew taps and PE input wiring
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_lane[i] = load_beat ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            b_lane[i] = load_beat ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        a_edge[0] = a_lane[0];
        b_edge[0] = b_lane[0];
        for (int i = 1; i < N; i++) begin
            a_edge[i] = a_sk[i][i-1];
            b_edge[i] = b_sk[i][i-1];
        end
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_edge[i];
            b_in[0][i] = b_edge[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_h[i][j-1];
                b_in[j][i] = b_v[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = mul_ext(a_in[i][j], b_in[i][j]);
            end
        end
    end

    // Row to load into c_row: row 0 on OUT entry, otherwise the next row
    always_comb begin
        row_sel = (state == DRAIN) ? '0 : RW'(c_row_idx + RW'(1));
        row_nxt = '0;
        for (int j = 0; j < N; j++) begin
            row_nxt[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_sel][j];
        end
    end

    // Skew lines, PE pipeline and accumulators; frozen outside LOAD/DRAIN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 1; i < N; i++) begin
                for (int s = 0; s < N - 1; s++) begin
                    a_sk[i][s] <= '0;
                    b_sk[i][s] <= '0;
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int m = 0; m < N - 1; m++) begin
                    a_h[i][m] <= '0;
                    b_v[m][i] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                end
            end
        end else if (adv) begin
            for (int i = 1; i < N; i++) begin
                a_sk[i][0] <= a_lane[i];
                b_sk[i][0] <= b_lane[i];
                for (int s = 1; s < N - 1; s++) begin
                    a_sk[i][s] <= a_sk[i][s-1];
                    b_sk[i][s] <= b_sk[i][s-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int m = 0; m < N - 1; m++) begin
                    a_h[i][m] <= a_in[i][m];
                    b_v[m][i] <= b_in[m][i];
                end
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + prod[i][j];
                end
            end
        end
    end

    // Job control and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_q       <= '0;
            beat_q    <= '0;
            drain_q   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            c_valid   <= 1'b0;
            c_row     <= '0;
            c_row_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q     <= k_len;
                        beat_q  <= '0;
                        drain_q <= '0;
                        busy    <= 1'b1;
                        if (k_len == '0) begin
                            state <= DRAIN;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        beat_q <= beat_q + KW'(1);
                        if (beat_q + KW'(1) == k_q) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // 2N-1 zero cycles flush the furthest PE before results are read
                    drain_q <= drain_q + DCW'(1);
                    if (drain_q == DRAIN_LAST) begin
                        state     <= OUT;
                        c_valid   <= 1'b1;
                        c_row_idx <= '0;
                        c_row     <= row_nxt;
                    end
                end
                OUT: begin
                    if (c_ready) begin
                        if (c_row_idx == ROW_LAST) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            c_valid   <= 1'b0;
                            c_row     <= '0;
                            c_row_idx <= '0;
                        end else begin
                            c_row_idx <= c_row_idx + RW'(1);
                            c_row     <= row_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
